// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle unsigned adder. It computes a + b + cin over WIDTH/DIGIT clock
// cycles and adds DIGIT bits per cycle. A carry flop links each digit to the
// next one. The design is area-lean and suits control-path arithmetic where
// latency is acceptable.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits added per cycle; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition (ignored while busy)
//   a, b   in   WIDTH-bit operands, captured when start is accepted
//   cin    in   carry-in, captured when start is accepted
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  registered result, holds until the next completion
//   cout   out  registered carry-out (bit WIDTH of the exact sum)
//   ovf    out  signed overflow flag; present only when SERIAL_ADDER_OVF_EN
//                is defined
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH, WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  // Digit datapath. Each bit is a full adder built from two half adders.
  // Bit 0 takes its carry-in from the carry flop.
  logic [DIGIT-1:0] digit_sum;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] acc_d;
  logic             carry_d;
  logic             last_digit;

  // NOTE: every variable written in an always_comb gets a value before any
  // conditional logic. Without that default the tool infers a latch.
  always_comb begin
    chain     = '0;
    digit_sum = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      logic hs;                            // first half adder: a ^ b
      hs           = a_q[i] ^ b_q[i];
      digit_sum[i] = hs ^ chain[i];        // second half adder adds the carry
      chain[i+1]   = (a_q[i] & b_q[i]) | (hs & chain[i]);
    end
    carry_d    = chain[DIGIT];
    // The accumulator fills from the MSB side. After CYCLES digits the first
    // digit has reached bit 0.
    acc_d      = (acc_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    last_digit = (cnt_q == CNT_W'(CYCLES - 1));
  end

`ifdef SERIAL_ADDER_OVF_EN
  // The operand shift registers lose their MSBs during the operation.
  // These flops keep the sign bits of the captured operands.
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together from values taken before the edge, with no order effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE accepts start exactly like IDLE, which allows back-to-back ops.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= carry_d;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_digit) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Three serial_adder instances: (8,1), (16,4) and (16,16). A countdown model
// derives busy/done timing and a + b + cin for each instance. A compare
// process checks every instance against the model on every falling edge.
// Directed sequences pin the model with hand-computed literals. Random
// operands then sweep the 16-bit instances.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  start_v = '0;
  logic [2:0]  cin_v   = '0;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];

  logic [2:0]  dut_busy, dut_done, dut_cout;
  logic [7:0]  sum0;
  logic [15:0] sum1, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic [2:0]  dut_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int wid [3] = '{8, 16, 16};
  int cyc [3] = '{8, 4, 1};

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .cin(cin_v[0]), .busy(dut_busy[0]), .done(dut_done[0]), .sum(sum0), .cout(dut_cout[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(dut_ovf[0])
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(dut_busy[1]), .done(dut_done[1]), .sum(sum1), .cout(dut_cout[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(dut_ovf[1])
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .busy(dut_busy[2]), .done(dut_done[2]), .sum(sum2), .cout(dut_cout[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(dut_ovf[2])
`endif
  );

  function automatic longint dut_sum(input int i);
    case (i)
      0:       return longint'(sum0);
      1:       return longint'(sum1);
      default: return longint'(sum2);
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. An accepted start computes the exact sum at once. The
  // result is published CYCLES edges later as a one-cycle done.
  // ---------------------------------------------------------------------------
  bit     m_busy [3] = '{0, 0, 0};
  bit     m_done [3] = '{0, 0, 0};
  bit     m_cout [3] = '{0, 0, 0};
  bit     m_ovf  [3] = '{0, 0, 0};
  int     m_rem  [3] = '{0, 0, 0};
  longint m_sum  [3] = '{0, 0, 0};
  longint m_full [3] = '{0, 0, 0};
  bit     m_ovfp [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 0; m_done[i] = 0; m_cout[i] = 0; m_ovf[i] = 0;
        m_rem[i] = 0;  m_sum[i] = 0;  m_full[i] = 0; m_ovfp[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_busy[i]) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_busy[i] = 0;
            m_done[i] = 1;
            m_sum[i]  = m_full[i] & ((64'd1 << wid[i]) - 1);
            m_cout[i] = m_full[i][wid[i]];
            m_ovf[i]  = m_ovfp[i];
          end
        end else begin
          m_done[i] = 0;
          if (start_v[i]) begin
            longint mask, av, bv;
            bit as, bs, ss;
            mask      = (64'd1 << wid[i]) - 1;
            av        = longint'(a_v[i]) & mask;
            bv        = longint'(b_v[i]) & mask;
            m_full[i] = av + bv + longint'(cin_v[i]);
            as        = av[wid[i]-1];
            bs        = bv[wid[i]-1];
            ss        = m_full[i][wid[i]-1];
            m_ovfp[i] = (as == bs) && (ss != as);
            m_busy[i] = 1;
            m_rem[i]  = cyc[i];
          end
        end
      end
    end
  end

  // Compare process: every instance, every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy[%0d]", i), longint'(dut_busy[i]), longint'(m_busy[i]));
      check($sformatf("done[%0d]", i), longint'(dut_done[i]), longint'(m_done[i]));
      check($sformatf("sum[%0d]", i),  dut_sum(i),            m_sum[i]);
      check($sformatf("cout[%0d]", i), longint'(dut_cout[i]), longint'(m_cout[i]));
      check($sformatf("busy_and_done[%0d]", i), longint'(dut_busy[i] & dut_done[i]), 0);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("ovf[%0d]", i),  longint'(dut_ovf[i]),  longint'(m_ovf[i]));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Each helper is entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    a_v[i]     = a;
    b_v[i]     = b;
    cin_v[i]   = c;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // Counts busy cycles until done shows up and checks the count.
  task automatic wait_done(input int i, input int exp_busy, input string name);
    int cnt   = 0;
    int guard = 0;
    while (!dut_done[i] && guard < 60) begin
      if (dut_busy[i]) cnt++;
      guard++;
      @(negedge clk);
    end
    if (!dut_done[i]) check({name, "_timeout"}, 0, 1);
    check({name, "_busy_cycles"}, cnt, exp_busy);
  endtask

  task automatic expect_no_done(input int i, input int n, input string name);
    int nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (dut_done[i]) nd++;
    end
    check(name, nd, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", dut_busy[0], 0);
    check("reset_done", dut_done[0], 0);
    check("reset_sum",  sum0, 0);
    check("reset_cout", dut_cout[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic timing: 0x12 + 0x34.
    start_op(0, 16'h12, 16'h34, 1'b0);
    check("basic_sum_holds", sum0, 0);
    wait_done(0, 8, "basic");
    check("basic_sum",  sum0, 8'h46);
    check("basic_cout", dut_cout[0], 0);

    // Wrap-around.
    @(negedge clk);
    start_op(0, 16'hFF, 16'h01, 1'b0);
    wait_done(0, 8, "wrap1");
    check("wrap1_sum",  sum0, 8'h00);
    check("wrap1_cout", dut_cout[0], 1);
    @(negedge clk);
    start_op(0, 16'hFF, 16'hFF, 1'b1);
    wait_done(0, 8, "wrap2");
    check("wrap2_sum",  sum0, 8'hFF);
    check("wrap2_cout", dut_cout[0], 1);

    // Ignored start: a second start at cycle 3 of the operation.
    @(negedge clk);
    start_op(0, 16'h0F, 16'h01, 1'b0);
    repeat (2) @(negedge clk);
    start_op(0, 16'hAA, 16'h55, 1'b0);
    // Three of the eight busy cycles have already elapsed.
    wait_done(0, 5, "ignored");
    check("ignored_sum", sum0, 8'h10);
    expect_no_done(0, 12, "ignored_no_second_done");

    // Back-to-back: a start held during the DONE cycle.
    start_op(0, 16'h01, 16'h01, 1'b0);
    wait_done(0, 8, "b2b_first");
    check("b2b_first_sum", sum0, 8'h02);
    start_op(0, 16'h80, 16'h80, 1'b0);
    check("b2b_done_falls", dut_done[0], 0);
    wait_done(0, 8, "b2b_second");
    check("b2b_second_sum",  sum0, 8'h00);
    check("b2b_second_cout", dut_cout[0], 1);

    // Mid-operation asynchronous reset. cout is 1 beforehand.
    @(negedge clk);
    start_op(0, 16'h55, 16'h22, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", dut_busy[0], 0);
    check("midrst_done", dut_done[0], 0);
    check("midrst_sum",  sum0, 0);
    check("midrst_cout", dut_cout[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done(0, 12, "midrst_no_done");
    start_op(0, 16'h03, 16'h04, 1'b0);
    wait_done(0, 8, "after_rst");
    check("after_rst_sum", sum0, 8'h07);

    // Random operands on the 8-bit instance.
    for (int n = 0; n < 30; n++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom_range(255));
      rb = 16'($urandom_range(255));
      rc = 1'($urandom_range(1));
      @(negedge clk);
      start_op(0, ra, rb, rc);
      wait_done(0, 8, "rand8");
      check("rand8_result", {dut_cout[0], sum0}, longint'(ra) + longint'(rb) + longint'(rc));
    end

    // Parameter sweep: 16/4 and 16/16.
    for (int inst = 1; inst < 3; inst++) begin
      for (int n = 0; n < 200; n++) begin
        logic [15:0] ra, rb;
        logic        rc;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(1));
        @(negedge clk);
        start_op(inst, ra, rb, rc);
        wait_done(inst, cyc[inst], $sformatf("sweep%0d", inst));
        check($sformatf("sweep%0d_result", inst),
              {64'(dut_cout[inst]), 16'(dut_sum(inst))},
              longint'(ra) + longint'(rb) + longint'(rc));
      end
    end

`ifdef SERIAL_ADDER_OVF_EN
    @(negedge clk);
    start_op(1, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(1, 4, "ovf_pos");
    check("ovf_pos_flag", dut_ovf[1], 1);
    @(negedge clk);
    start_op(1, 16'h8000, 16'hFFFF, 1'b0);
    wait_done(1, 4, "ovf_neg");
    check("ovf_neg_flag", dut_ovf[1], 1);
    check("ovf_neg_cout", dut_cout[1], 1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
- Each digit is summed by a chained half-adder/full-adder datapath, and a carry flip-flop links one digit to the next.
- Start/busy/done handshake.
- Successor to the combinational half adder. It is the area-lean adder for control-path arithmetic where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥2.
- DIGIT, 1, bits added per cycle. Must divide WIDTH exactly; a non-dividing value is an elaboration error.
- CYCLES, WIDTH/DIGIT, localparam. Number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled on clk rising edge
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  registered carry-out; holds until the next completion

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: busy=0, done=0, sum=0, cout=0. Internal operand shift registers, carry flop and digit counter all clear to 0. FSM goes to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: capture a, b, cin; counter=0; go to RUN; busy=1 from that edge.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge adds the low DIGIT bits of the A/B shift registers plus the carry flop.
  - The DIGIT-bit result is shifted into the accumulator from the MSB side. The carry flop takes the digit's carry-out. Both operand registers shift right by DIGIT.
  - The counter increments each edge.
  - On the edge that processes digit CYCLES-1: sum ← final accumulator, cout ← final carry, done=1, busy=0; go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 during it.
  - start=1 in DONE is accepted exactly as in IDLE: capture operands, go to RUN, busy=1, done falls.
  - Otherwise go to IDLE.
- Latency: the start edge is edge k. done and the new sum/cout are visible after edge k+CYCLES. Throughput is one result per CYCLES+1 cycles; back-to-back starts from DONE are allowed.
- start while busy=1 is ignored. The in-flight operation is unaffected, and a/b/cin changes are ignored.
- sum/cout change only on the completion edge, never mid-operation.
- Arithmetic: result = a + b + cin, unsigned. cout is bit WIDTH of the exact sum. Wrap-around is modulo 2^WIDTH.
- DIGIT=WIDTH is legal: CYCLES=1, one RUN cycle.
- Reset asserted mid-RUN:
  - The operation is aborted immediately; all outputs return to reset values.
  - No done pulse follows after reset release.
  - The first start after release behaves as from IDLE.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit, reset 0.
  - Registered with sum/cout on the completion edge.
  - ovf = signed two's-complement overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the captured operands. cin is included in the sum.
  - Holds until the next completion.
- Not defined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- Basic timing, WIDTH=8, DIGIT=1: start pulse with a=0x12, b=0x34, cin=0.
  - busy=1 for 8 cycles, then done=1 for one cycle.
  - sum=0x46, cout=0.
  - sum holds 0x00 (reset value) until completion.
- Wrap-around: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Ignored start, WIDTH=8, DIGIT=1: start with a=0x0F, b=0x01, then start again at cycle 3 with a=0xAA, b=0x55.
  - Only one done pulse, after 8 cycles.
  - sum=0x10.
  - The second start has no effect.
- Back-to-back, WIDTH=8, DIGIT=1:
  - Start a=0x01, b=0x01. Then hold start=1 in the DONE cycle with a=0x80, b=0x80.
  - First done gives sum=0x02.
  - Second done follows 8 cycles later with sum=0x00, cout=1.
- Mid-operation reset, WIDTH=8, DIGIT=1: start a=0x55, b=0x22; assert rst_n=0 asynchronously at cycle 4.
  - busy, done, sum and cout go to 0 immediately.
  - No done after release.
  - A new start (a=0x03, b=0x04) yields sum=0x07.
- Parameter sweep: WIDTH=16 with DIGIT=4, and WIDTH=16 with DIGIT=16, 200 random a/b/cin each.
  - done arrives 4 cycles and 1 cycle after start respectively.
  - {cout,sum} matches a+b+cin.
  - With SERIAL_ADDER_OVF_EN, a=0x7FFF, b=0x0001 → ovf=1; a=0x8000, b=0xFFFF → ovf=1, cout=1.
